vend_change_fsm: RTL and testbench



---
 rtl/vend_change_fsm.sv | 120 ++++++++++++
 tb/tb_vend_change_fsm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_fsm.sv
// Vending-machine controller with configurable price, quarter acceptance,
// cancel/refund and change paid one nickel per cycle.
module vend_change_fsm #(
   parameter int PRICE    = 20,
   parameter int CREDIT_W = 7
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                nickel_in,
   input  logic                dime_in,
   input  logic                quarter_in,
   input  logic                cancel_in,
   output logic                dispense,
   output logic                nickel_out,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit
);

   localparam longint MAX_CREDIT = (longint'(1) << CREDIT_W) - 1;

   if ((PRICE < 5) || ((PRICE % 5) != 0)) begin : g_bad_price
      $fatal(1, "vend_change_fsm: PRICE must be a multiple of 5 and at least 5");
   end
   if (longint'(PRICE + 20) > MAX_CREDIT) begin : g_bad_width
      $fatal(1, "vend_change_fsm: CREDIT_W too narrow to hold PRICE+20");
   end

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_VEND   = 2'd1,
      ST_CHANGE = 2'd2
   } state_t;

   localparam logic [CREDIT_W-1:0] C_NICKEL  = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] C_DIME    = CREDIT_W'(10);
   localparam logic [CREDIT_W-1:0] C_QUARTER = CREDIT_W'(25);
   localparam logic [CREDIT_W-1:0] C_PRICE   = CREDIT_W'(PRICE);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] w_credit_nxt;
   logic [CREDIT_W-1:0] r_change;
   logic [CREDIT_W-1:0] w_change_nxt;
   logic [CREDIT_W-1:0] w_coin_val;
   logic [CREDIT_W-1:0] w_sum;

   // Only the most valuable coin seen in a cycle is credited.
   always_comb begin
      if (quarter_in) begin
         w_coin_val = C_QUARTER;
      end else if (dime_in) begin
         w_coin_val = C_DIME;
      end else if (nickel_in) begin
         w_coin_val = C_NICKEL;
      end else begin
         w_coin_val = '0;
      end
   end

   // Cannot wrap: credit before a coin never exceeds PRICE-5.
   assign w_sum = r_credit + w_coin_val;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_ACCEPT;
         r_credit <= '0;
         r_change <= '0;
      end else begin
         // NOTE: non-blocking so every register updates from pre-edge values.
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
         r_change <= w_change_nxt;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case can infer a latch.
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_change_nxt = r_change;
      case (r_state)
         ST_ACCEPT: begin
            if (cancel_in) begin
               w_change_nxt = w_sum;
               w_credit_nxt = '0;
               if (w_sum != '0) begin
                  w_state_nxt = ST_CHANGE;
               end
            end else if (w_coin_val != '0) begin
               if (w_sum >= C_PRICE) begin
                  w_change_nxt = w_sum - C_PRICE;
                  w_credit_nxt = '0;
                  w_state_nxt  = ST_VEND;
               end else begin
                  w_credit_nxt = w_sum;
               end
            end
         end
         ST_VEND: begin
            w_state_nxt = (r_change != '0) ? ST_CHANGE : ST_ACCEPT;
         end
         ST_CHANGE: begin
            w_change_nxt = r_change - C_NICKEL;
            if (r_change == C_NICKEL) begin
               w_state_nxt = ST_ACCEPT;
            end
         end
         default: begin
            w_state_nxt = ST_ACCEPT;
         end
      endcase
   end

   assign dispense   = (r_state == ST_VEND);
   assign nickel_out = (r_state == ST_CHANGE);
   assign busy       = (r_state != ST_ACCEPT);
   assign credit     = r_credit;

endmodule

// File: tb/tb_vend_change_fsm.sv
// Self-checking bench for vend_change_fsm: directed scenarios plus a random
// run compared against a transaction-level model of the vending rules.
module tb_vend_change_fsm;

   localparam int PRICE    = 20;
   localparam int CREDIT_W = 7;
   localparam int OBS_W    = CREDIT_W + 3;

   // Stimulus word layout: {reset, cancel, quarter, dime, nickel}
   localparam logic [4:0] S_I = 5'b00000;
   localparam logic [4:0] S_N = 5'b00001;
   localparam logic [4:0] S_D = 5'b00010;
   localparam logic [4:0] S_Q = 5'b00100;
   localparam logic [4:0] S_C = 5'b01000;
   localparam logic [4:0] S_R = 5'b10000;

   logic                clock;
   logic                reset;
   logic                nickel_in;
   logic                dime_in;
   logic                quarter_in;
   logic                cancel_in;
   logic                dispense;
   logic                nickel_out;
   logic                busy;
   logic [CREDIT_W-1:0] credit;
   logic [OBS_W-1:0]    obs;

   int n_cmp = 0;
   int n_err = 0;

   // Model: idle credit plus a queue of pending busy cycles (1=dispense, 2=nickel).
   int m_credit = 0;
   int m_q[$];

   vend_change_fsm #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .nickel_in  (nickel_in),
      .dime_in    (dime_in),
      .quarter_in (quarter_in),
      .cancel_in  (cancel_in),
      .dispense   (dispense),
      .nickel_out (nickel_out),
      .busy       (busy),
      .credit     (credit)
   );

   assign obs = {dispense, nickel_out, busy, credit};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [OBS_W-1:0] pk(input logic d, input logic n, input logic b,
                                           input int c);
      return {d, n, b, CREDIT_W'(c)};
   endfunction

   function automatic void model_step(input logic [4:0] s);
      int val;
      int tot;
      if (s[4]) begin
         m_q.delete();
         m_credit = 0;
      end else if (m_q.size() != 0) begin
         void'(m_q.pop_front());
      end else begin
         val = s[2] ? 25 : s[1] ? 10 : s[0] ? 5 : 0;
         tot = m_credit + val;
         if (s[3]) begin
            m_credit = 0;
            for (int k = 0; k < tot / 5; k++) m_q.push_back(2);
         end else if (val != 0) begin
            if (tot >= PRICE) begin
               m_credit = 0;
               m_q.push_back(1);
               for (int k = 0; k < (tot - PRICE) / 5; k++) m_q.push_back(2);
            end else begin
               m_credit = tot;
            end
         end
      end
   endfunction

   function automatic logic [OBS_W-1:0] model_obs();
      if (m_q.size() != 0) begin
         return (m_q[0] == 1) ? pk(1, 0, 1, 0) : pk(0, 1, 1, 0);
      end
      return pk(0, 0, 0, m_credit);
   endfunction

   // Apply one cycle of inputs, advance the model, and sample 1 time unit after the edge.
   task automatic drive(input logic [4:0] s);
      {reset, cancel_in, quarter_in, dime_in, nickel_in} = s;
      model_step(s);
      @(posedge clock);
      #1;
      {reset, cancel_in, quarter_in, dime_in, nickel_in} = 5'b00000;
   endtask

   task automatic test_reset();
      drive(S_R);
      n_cmp++;
      if (obs !== pk(0, 0, 0, 0)) begin
         n_err++;
         $display("FAIL reset_state: got %b_%0d want %b_%0d",
                  obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0], 3'b000, 0);
      end
      drive(S_R | S_Q | S_C);
      n_cmp++;
      if (obs !== pk(0, 0, 0, 0)) begin
         n_err++;
         $display("FAIL reset_priority: got %b_%0d want %b_%0d",
                  obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0], 3'b000, 0);
      end
   endtask

   task automatic test_exact_price();
      logic [4:0]       s [4];
      logic [OBS_W-1:0] e [4];
      s = '{S_D, S_D, S_I, S_I};
      e = '{pk(0, 0, 0, 10), pk(1, 0, 1, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0)};
      for (int i = 0; i < 4; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL exact_price step %0d: got %b_%0d want %b_%0d", i,
                     obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0], e[i][OBS_W-1 -: 3], e[i][CREDIT_W-1:0]);
         end
      end
   endtask

   task automatic test_quarter_change();
      logic [4:0]       s [3];
      logic [OBS_W-1:0] e [3];
      s = '{S_Q, S_I, S_I};
      e = '{pk(1, 0, 1, 0), pk(0, 1, 1, 0), pk(0, 0, 0, 0)};
      for (int i = 0; i < 3; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL quarter_change step %0d: got %b_%0d want %b_%0d", i,
                     obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0], e[i][OBS_W-1 -: 3], e[i][CREDIT_W-1:0]);
         end
      end
   endtask

   task automatic test_multi_change();
      logic [4:0]       s [8];
      logic [OBS_W-1:0] e [8];
      s = '{S_N, S_D, S_Q, S_I, S_I, S_I, S_I, S_I};
      e = '{pk(0, 0, 0, 5), pk(0, 0, 0, 15), pk(1, 0, 1, 0), pk(0, 1, 1, 0),
            pk(0, 1, 1, 0), pk(0, 1, 1, 0), pk(0, 1, 1, 0), pk(0, 0, 0, 0)};
      for (int i = 0; i < 8; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL multi_change step %0d: got %b_%0d want %b_%0d", i,
                     obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0], e[i][OBS_W-1 -: 3], e[i][CREDIT_W-1:0]);
         end
      end
   endtask

   task automatic test_cancel();
      logic [4:0]       s [11];
      logic [OBS_W-1:0] e [11];
      s = '{S_N, S_D, S_C, S_I, S_I, S_I, S_C, S_I, S_C | S_D, S_I, S_I};
      e = '{pk(0, 0, 0, 5), pk(0, 0, 0, 15), pk(0, 1, 1, 0), pk(0, 1, 1, 0),
            pk(0, 1, 1, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0),
            pk(0, 1, 1, 0), pk(0, 1, 1, 0), pk(0, 0, 0, 0)};
      for (int i = 0; i < 11; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL cancel step %0d: got %b_%0d want %b_%0d", i,
                     obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0], e[i][OBS_W-1 -: 3], e[i][CREDIT_W-1:0]);
         end
      end
   endtask

   task automatic test_coin_priority();
      logic [4:0]       s [7];
      logic [OBS_W-1:0] e [7];
      s = '{S_D | S_N, S_Q | S_D | S_N, S_Q, S_Q | S_C, S_I, S_I, S_I};
      e = '{pk(0, 0, 0, 10), pk(1, 0, 1, 0), pk(0, 1, 1, 0), pk(0, 1, 1, 0),
            pk(0, 1, 1, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0)};
      for (int i = 0; i < 7; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL coin_priority step %0d: got %b_%0d want %b_%0d", i,
                     obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0], e[i][OBS_W-1 -: 3], e[i][CREDIT_W-1:0]);
         end
      end
   endtask

   task automatic test_reset_mid_change();
      logic [4:0]       s [10];
      logic [OBS_W-1:0] e [10];
      s = '{S_N, S_D, S_Q, S_I, S_I, S_R, S_D, S_C, S_I, S_I};
      e = '{pk(0, 0, 0, 5), pk(0, 0, 0, 15), pk(1, 0, 1, 0), pk(0, 1, 1, 0),
            pk(0, 1, 1, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 10), pk(0, 1, 1, 0),
            pk(0, 1, 1, 0), pk(0, 0, 0, 0)};
      for (int i = 0; i < 10; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL reset_mid_change step %0d: got %b_%0d want %b_%0d", i,
                     obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0], e[i][OBS_W-1 -: 3], e[i][CREDIT_W-1:0]);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0]       s;
      logic [OBS_W-1:0] exp_obs;
      for (int i = 0; i < 3000; i++) begin
         s[4] = ($urandom_range(0, 149) == 0);
         s[3] = ($urandom_range(0, 11) == 0);
         s[2] = ($urandom_range(0, 3) == 0);
         s[1] = ($urandom_range(0, 2) == 0);
         s[0] = ($urandom_range(0, 2) == 0);
         drive(s);
         exp_obs = model_obs();
         n_cmp++;
         if (obs !== exp_obs) begin
            n_err++;
            $display("FAIL random cycle %0d stim %b: got %b_%0d want %b_%0d", i, s,
                     obs[OBS_W-1 -: 3], obs[CREDIT_W-1:0],
                     exp_obs[OBS_W-1 -: 3], exp_obs[CREDIT_W-1:0]);
         end
      end
   endtask

   initial begin
      {reset, cancel_in, quarter_in, dime_in, nickel_in} = 5'b00000;
      test_reset();
      test_exact_price();
      test_quarter_change();
      test_multi_change();
      test_cancel();
      test_coin_priority();
      test_reset_mid_change();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
